phase_controller: RTL and testbench
===================================

# phase_controller

Multi-cycle phase sequencer for the processor core. It drives the one-hot phase enables p1..p5 that step every datapath register through fetch, instruction-register load, decode, execute and write-back. The instruction register consumes p2 directly. The block also handles run/stop/single-step control, memory wait stalls in the load phase, and halt-instruction detection. It keeps a count of retired instructions.

## Interface
Parameters:
- COUNT_W, 16, width of the retired-instruction counter

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 forces all state to reset values immediately
- start  input  1  run request, sampled each cycle; acted on only in IDLE or HALTED
- stop  input  1  stop request, sampled each cycle; acted on only while running
- step  input  1  single-step mode level; when 1, the core runs one instruction, then returns to IDLE
- mem_ready  input  1  instruction memory data valid; a 0 holds phase P2
- halt_inst  input  1  from the decoder; 1 means the current instruction is a halt; sampled in P5 only
- p1, p2, p3, p4, p5  output  1 each  phase enables, one-hot while running, all 0 otherwise
- running  output  1  1 when the state is P1..P5
- halted  output  1  1 when the state is HALTED
- inst_count  output  COUNT_W  retired-instruction count

## Operation
- States: IDLE, P1, P2, P3, P4, P5, HALTED. Encoding is free.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- pk = 1 exactly when state == Pk.
- Transitions, evaluated on each rising clock edge:
  - IDLE: start=1 → P1; otherwise stay in IDLE.
  - P1 → P2 unconditionally.
  - P2: mem_ready=1 → P3; mem_ready=0 → stay in P2. p2 stays high, so the instruction register reloads each stalled cycle.
  - P3 → P4 → P5 unconditionally.
  - P5: always increment inst_count, then take the first matching exit in priority order:
    1. halt_inst=1 → HALTED
    2. stop=1 or stop_pending=1 → IDLE
    3. step=1 → IDLE
    4. otherwise → P1
  - HALTED: start=1 → P1; otherwise stay in HALTED.
- stop_pending register:
  - Set when stop=1 in any of P1..P4.
  - Cleared on any transition out of P5.
  - stop in IDLE or HALTED is ignored and does not set stop_pending.
- A stop never aborts a partially executed instruction. It takes effect only at the P5 boundary.
- inst_count increments by 1 per P5 cycle, modulo 2^COUNT_W; all-ones wraps to 0. The count is held across IDLE and HALTED, and only reset clears it.
- start=1 and stop=1 in the same IDLE cycle: start wins and the stop is ignored.
- start while running is ignored.

## Timing
- Reset values: state IDLE, p1..p5=0, running=0, halted=0, inst_count=0, stop_pending=0.
- Reset is asserted asynchronously. Deassertion is synchronised externally. The first edge after deassertion evaluates IDLE.
- Reset asserted mid-instruction, in any phase: outputs go to reset values without waiting for a clock edge. The partial instruction is abandoned.
- Latency:
  - start sampled in IDLE → p1=1 in the next cycle.
  - Nominal instruction: 5 cycles, P1..P5.
  - Each cycle with mem_ready=0 in P2 adds one cycle.
- Back-to-back instructions: P5 is followed directly by P1, with no bubble.
- inst_count shows the new value in the cycle after P5.
- halted=1 starts in the cycle after the P5 that sampled halt_inst=1.
- Exactly one of {IDLE, HALTED, P1..P5} is active in every cycle.

## Test plan
- Reset and run:
  - Stimulus: hold reset=0 for 3 cycles, then release; start=1 for 1 cycle.
  - Required: all outputs 0 during reset; p1..p5 pulse in order, one cycle each; pattern repeats with no gaps; inst_count=3 after 15 cycles of running.
- Memory stall:
  - Stimulus: mem_ready=0 for 4 cycles on entering P2.
  - Required: p2 high for 5 consecutive cycles; P3 follows on the cycle after mem_ready=1; instruction length is 9 cycles.
- Halt:
  - Stimulus: halt_inst=1 during the 2nd instruction's P5.
  - Required: halted=1, running=0, inst_count=2, p outputs stay 0 with start=0; start=1 resumes with p1 in the next cycle.
- Stop and step:
  - Stop: a stop pulse in P3 completes that instruction, then goes to IDLE, with inst_count +1.
  - Step: step=1 with 3 start pulses gives exactly 3 instructions, returning to IDLE after each P5.
- Wrap and async reset:
  - Wrap: with COUNT_W=4, 17 instructions give inst_count=1.
  - Async reset: reset=0 asserted mid-P4, between clock edges, clears all outputs immediately; stop_pending is cleared.

Source files
------------

// File: rtl/phase_controller.sv
`default_nettype none
// ============================================================================
// phase_controller : one-hot P1..P5 phase sequencer with run/stop/step/halt
// Revision 1.0
// ============================================================================
module phase_controller #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               mem_ready,
  input  logic               halt_inst,
  output logic               p1,
  output logic               p2,
  output logic               p3,
  output logic               p4,
  output logic               p5,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] inst_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1     = 3'd1,
    P2     = 3'd2,
    P3     = 3'd3,
    P4     = 3'd4,
    P5     = 3'd5,
    HALTED = 3'd6
  } state_t;

  localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t next_state;
  logic   stop_pending;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start) next_state = P1;
      P1:     next_state = P2;
      P2:     if (mem_ready) next_state = P3;
      P3:     next_state = P4;
      P4:     next_state = P5;
      // Instruction boundary: halt beats stop, stop beats single-step.
      P5: begin
        if (halt_inst)                  next_state = HALTED;
        else if (stop || stop_pending)  next_state = IDLE;
        else if (step)                  next_state = IDLE;
        else                            next_state = P1;
      end
      HALTED: if (start) next_state = P1;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they track the state register exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
      inst_count   <= '0;
      p1           <= 1'b0;
      p2           <= 1'b0;
      p3           <= 1'b0;
      p4           <= 1'b0;
      p5           <= 1'b0;
      running      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state   <= next_state;
      p1      <= (next_state == P1);
      p2      <= (next_state == P2);
      p3      <= (next_state == P3);
      p4      <= (next_state == P4);
      p5      <= (next_state == P5);
      running <= (next_state inside {P1, P2, P3, P4, P5});
      halted  <= (next_state == HALTED);
      if (state == P5) begin
        inst_count   <= inst_count + ONE;
        stop_pending <= 1'b0;
      end else if (stop && (state inside {P1, P2, P3, P4})) begin
        stop_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_controller.sv
`default_nettype none
// Testbench for phase_controller: directed scenarios plus random run against a cycle model.
module tb_phase_controller;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset, start, stop, step, mem_ready, halt_inst;
  logic p1, p2, p3, p4, p5, running, halted;
  logic [CW-1:0] inst_count;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 = idle, 1..5 = Pk, 6 = halted
  int m_phase;
  bit m_pend;
  int m_cnt;

  logic [CW+6:0] obs;
  assign obs = {p1, p2, p3, p4, p5, running, halted, inst_count};

  phase_controller #(.COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .step(step),
    .mem_ready(mem_ready), .halt_inst(halt_inst),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
    .running(running), .halted(halted), .inst_count(inst_count)
  );

  always #5 clock = ~clock;

  function automatic logic [CW+6:0] exp_vec();
    logic [4:0] p;
    logic [CW-1:0] c;
    p = 5'b0;
    if (m_phase >= 1 && m_phase <= 5) p[5-m_phase] = 1'b1;
    c = CW'(m_cnt);
    return {p, (m_phase >= 1 && m_phase <= 5), (m_phase == 6), c};
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_pend = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    case (m_phase)
      0, 6: if (start) m_phase = 1;
      1, 3, 4: begin if (stop) m_pend = 1; m_phase = m_phase + 1; end
      2: begin if (stop) m_pend = 1; if (mem_ready) m_phase = 3; end
      5: begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (halt_inst) m_phase = 6;
        else if (stop || m_pend || step) m_phase = 0;
        else m_phase = 1;
        m_pend = 0;
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clock);
    if (reset) model_step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 0; stop = 0; step = 0; mem_ready = 1; halt_inst = 0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; stop = 0; step = 0; mem_ready = 1; halt_inst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset cyc%0d obs=%h exp=0", i, obs); end
    end
    reset = 1'b1;
  endtask

  task automatic test_run();
    do_reset();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({p1, p2, p3, p4, p5} !== (5'b10000 >> (i % 5)) || obs !== exp_vec()) begin
        bad++; $display("FAIL run cyc%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      if (i < 15) cyc();
    end
    total++;
    if (inst_count !== CW'(3)) begin bad++; $display("FAIL run_count got=%0d exp=3", inst_count); end
  endtask

  task automatic test_stall();
    int p2cnt = 0;
    int len = 1;
    do_reset();
    start = 1; cyc(); start = 0;
    mem_ready = 0;
    cyc();
    while (p2 === 1'b1 && p2cnt < 10) begin
      p2cnt++;
      if (p2cnt == 5) mem_ready = 1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL stall cyc%0d obs=%h exp=%h", p2cnt, obs, exp_vec()); end
      cyc(); len++;
    end
    total++;
    if (p2cnt != 5 || p3 !== 1'b1) begin bad++; $display("FAIL stall_p2 got=%0d p3=%b exp=5 p3=1", p2cnt, p3); end
    while (p1 !== 1'b1 && len < 20) begin cyc(); len++; end
    total++;
    if (len != 9) begin bad++; $display("FAIL stall_len got=%0d exp=9", len); end
  endtask

  task automatic test_halt();
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (9) cyc();
    total++;
    if (p5 !== 1'b1) begin bad++; $display("FAIL halt_p5 got=%b exp=1", p5); end
    halt_inst = 1; cyc(); halt_inst = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({halted, running, inst_count, p1, p2, p3, p4, p5} !== {1'b1, 1'b0, CW'(2), 5'b0} || obs !== exp_vec()) begin
        bad++; $display("FAIL halt_hold cyc%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      cyc();
    end
    start = 1; cyc(); start = 0;
    total++;
    if (p1 !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_resume p1=%b halted=%b exp p1=1 halted=0", p1, halted); end
  endtask

  task automatic test_stop();
    do_reset();
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    stop = 1; cyc(); stop = 0;
    cyc(); cyc();
    total++;
    if ({running, halted, inst_count} !== {2'b00, CW'(1)} || obs !== exp_vec()) begin
      bad++; $display("FAIL stop_idle obs=%h exp=%h", obs, exp_vec());
    end
    // start and stop together in IDLE: start wins, stop leaves nothing pending
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    repeat (5) cyc();
    total++;
    if (p1 !== 1'b1 || inst_count !== CW'(2)) begin
      bad++; $display("FAIL stop_start_same p1=%b cnt=%0d exp p1=1 cnt=2", p1, inst_count);
    end
  endtask

  task automatic test_step();
    do_reset();
    step = 1;
    for (int k = 0; k < 3; k++) begin
      start = 1; cyc(); start = 0;
      repeat (4) cyc();
      total++;
      if (p5 !== 1'b1) begin bad++; $display("FAIL step_p5 k=%0d got=%b exp=1", k, p5); end
      cyc();
      total++;
      if (running !== 1'b0 || inst_count !== CW'(k + 1) || obs !== exp_vec()) begin
        bad++; $display("FAIL step_idle k=%0d obs=%h exp=%h", k, obs, exp_vec());
      end
      cyc();
    end
    step = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    start = 1; cyc(); start = 0;
    repeat (85) cyc();
    total++;
    if (inst_count !== CW'(1) || p1 !== 1'b1) begin
      bad++; $display("FAIL wrap got=%0d p1=%b exp=1 p1=1", inst_count, p1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1; cyc(); start = 0;
    stop = 1; cyc(); stop = 0;
    cyc(); cyc();
    total++;
    if (p4 !== 1'b1) begin bad++; $display("FAIL areset_p4 got=%b exp=1", p4); end
    #2 reset = 0;
    model_reset();
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL areset_clear obs=%h exp=0", obs); end
    @(negedge clock);
    reset = 1;
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    total++;
    if (p1 !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL areset_pending obs=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom % 4) == 0;
      stop      = ($urandom % 16) == 0;
      step      = ($urandom % 8) == 0;
      mem_ready = ($urandom % 4) != 0;
      halt_inst = ($urandom % 12) == 0;
      if (($urandom % 150) == 0) begin
        reset = 0;
        model_reset();
      end
      cyc();
      reset = 1;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc%0d obs=%h exp=%h", i, obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_halt();
    test_stop();
    test_step();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
